mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, max WAIT cycles before an access is abandoned.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 ALUResult_i  in  32  EX/MEM ALU result; memory address for loads and stores.
REQ-005 RTdata_i  in  32  EX/MEM store data.
REQ-006 RDaddr_i  in  5  EX/MEM destination register.
REQ-007 MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  EX/MEM control bits.
REQ-008 stall_o  out  1  freeze EX/MEM and upstream stages this cycle.
REQ-009 mem_req_o  out  1  data-memory request, held until ack or timeout.
REQ-010 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o.
REQ-011 mem_addr_o, mem_wdata_o  out  32 each  latched address and store data.
REQ-012 mem_ack_i  in  1  one-cycle completion pulse from memory.
REQ-013 mem_rdata_i  in  32  read data, valid with mem_ack_i.
REQ-014 RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control bits.
REQ-015 ALUResult_o, ReadData_o  out  32 each  MEM/WB data.
REQ-016 RDaddr_o  out  5  MEM/WB destination register.
REQ-017 err_o  out  1  sticky timeout flag.
REQ-018 stall_cnt_o  out  32  saturating count of cycles with stall_o=1.

Function
REQ-019 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-020 IDLE, no access (MemRead_i=MemWrite_i=0): stall_o=0; MEM/WB regs load inputs, ReadData_o<=0; one-cycle latency.
REQ-021 IDLE, access present: stall_o=1 (combinational); latch addr, wdata, we=MemWrite_i, RegWrite, MemtoReg, RDaddr; mem_req_o<=1; MEM/WB loads bubble; ->WAIT.
REQ-022 MemRead_i and MemWrite_i both 1: treated as write.
REQ-023 Bubble = RegWrite_o=0, MemtoReg_o=0; data outputs hold previous values.
REQ-024 WAIT: stall_o=1, mem_req_o=1, address/data stable; MEM/WB loads bubble each cycle.
REQ-025 WAIT with mem_ack_i=1: latch mem_rdata_i (reads only); mem_req_o<=0; ->DONE.
REQ-026 WAIT cycle counter reaching TIMEOUT without ack: mem_req_o<=0, err_o<=1, latched rdata<=0; ->DONE.
REQ-027 mem_ack_i on the same cycle as timeout: ack wins, err_o unchanged.
REQ-028 mem_ack_i outside WAIT: ignored.
REQ-029 DONE: stall_o=0; MEM/WB loads latched controls, ALUResult, RDaddr, ReadData; ->IDLE.
REQ-030 Minimum memory-op occupancy is 3 cycles (IDLE, WAIT with ack, DONE); back-to-back accesses re-enter via IDLE with no extra gap.
REQ-031 stall_cnt_o increments each stall_o=1 cycle, saturating at 0xFFFFFFFF.
REQ-032 err_o clears only on reset.

Reset
REQ-033 rst_i low: immediately state=IDLE, mem_req_o=0, mem_we_o=0, stall_o=0, all MEM/WB outputs 0, err_o=0, stall_cnt_o=0, latches and timeout counter 0.
REQ-034 Reset during WAIT: request dropped in the same cycle; the pending access is discarded, not replayed.

Structure
REQ-035 State encoding and width constants (DATA_W=32, REG_W=5) go in shared package cpu_pkg.
REQ-036 Single sub-module mem_wb_reg holds the MEM/WB output register with load and bubble controls; FSM, latches and counters live in mem_wb_stage.

Verification
REQ-037 ALU op (RegWrite_i=1, RDaddr_i=5, ALUResult_i=0x10) -> next cycle RegWrite_o=1, RDaddr_o=5, ALUResult_o=0x10, stall_o never 1.
REQ-038 Load addr 0x40, ack after 3 WAIT cycles with rdata 0xDEADBEEF -> stall_o high 4 cycles, ReadData_o=0xDEADBEEF, MemtoReg_o=1, stall_cnt_o=4.
REQ-039 Store addr 0x80 data 0x1234, ack in first WAIT -> mem_we_o=1 for 1 cycle, RegWrite_o=0, 3-cycle occupancy.
REQ-040 No ack, TIMEOUT=16 -> mem_req_o drops after 16 WAIT cycles, err_o=1, ReadData_o=0.
REQ-041 rst_i low during WAIT -> mem_req_o=0 and stall_o=0 without a clock edge; after release, a new load completes normally.
REQ-042 Two back-to-back loads, both acked immediately -> 6 cycles total, results in order.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the MEM/WB stage state encoding.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load captures the next stage contents; a bubble
// clears the write-back controls and leaves the data fields untouched.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_regwrite,
    input  logic              i_memtoreg,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [REG_W-1:0]  i_rdaddr,
    output logic              o_regwrite,
    output logic              o_memtoreg,
    output logic [DATA_W-1:0] o_alu,
    output logic [DATA_W-1:0] o_rdata,
    output logic [REG_W-1:0]  o_rdaddr
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
            o_alu      <= '0;
            o_rdata    <= '0;
            o_rdaddr   <= '0;
        end else if (i_load) begin
            o_regwrite <= i_regwrite;
            o_memtoreg <= i_memtoreg;
            o_alu      <= i_alu;
            o_rdata    <= i_rdata;
            o_rdaddr   <= i_rdaddr;
        end else if (i_bubble) begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: runs one data-memory request/ack handshake per load or store,
// stalling upstream until the access completes or times out.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [REG_W-1:0]  RDaddr_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [REG_W-1:0]  RDaddr_o,
    output logic              err_o,
    output logic [DATA_W-1:0] stall_cnt_o
);

    localparam int                TCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + DATA_W'(1);
    endfunction

    mem_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [REG_W-1:0]  r_rdaddr;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err;
    logic [DATA_W-1:0] r_stall_cnt;

    logic              w_access;
    logic              w_stall;
    logic              w_load;
    logic              w_bubble;
    logic              w_wb_regwrite;
    logic              w_wb_memtoreg;
    logic [DATA_W-1:0] w_wb_alu;
    logic [DATA_W-1:0] w_wb_rdata;
    logic [REG_W-1:0]  w_wb_rdaddr;

    // Stall is gated by reset so upstream is released the instant reset asserts.
    always_comb begin
        w_access      = MemRead_i | MemWrite_i;
        w_stall       = rst_i && (((r_state == ST_IDLE) && w_access) || (r_state == ST_WAIT));
        w_load        = 1'b0;
        w_bubble      = 1'b0;
        w_wb_regwrite = RegWrite_i;
        w_wb_memtoreg = MemtoReg_i;
        w_wb_alu      = ALUResult_i;
        w_wb_rdata    = '0;
        w_wb_rdaddr   = RDaddr_i;
        case (r_state)
            ST_IDLE: begin
                w_load   = !w_access;
                w_bubble = w_access;
            end
            ST_WAIT: w_bubble = 1'b1;
            ST_DONE: begin
                w_load        = 1'b1;
                w_wb_regwrite = r_regwrite;
                w_wb_memtoreg = r_memtoreg;
                w_wb_alu      = r_addr;
                w_wb_rdata    = r_rdata;
                w_wb_rdaddr   = r_rdaddr;
            end
            default: w_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_rdaddr    <= '0;
            r_tcnt      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_addr     <= ALUResult_i;
                        r_wdata    <= RTdata_i;
                        r_we       <= MemWrite_i;
                        r_regwrite <= RegWrite_i;
                        r_memtoreg <= MemtoReg_i;
                        r_rdaddr   <= RDaddr_i;
                        r_rdata    <= '0;
                        r_tcnt     <= '0;
                        r_req      <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the final allowed cycle still completes the access.
                    if (mem_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_tcnt == TCNT_LAST) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_o     = w_stall;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign err_o       = r_err;
    assign stall_cnt_o = r_stall_cnt;

    mem_wb_reg u_mem_wb_reg (
        .i_clk      (clk_i),
        .i_rst_n    (rst_i),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_regwrite (w_wb_regwrite),
        .i_memtoreg (w_wb_memtoreg),
        .i_alu      (w_wb_alu),
        .i_rdata    (w_wb_rdata),
        .i_rdaddr   (w_wb_rdaddr),
        .o_regwrite (RegWrite_o),
        .o_memtoreg (MemtoReg_o),
        .o_alu      (ALUResult_o),
        .o_rdata    (ReadData_o),
        .o_rdaddr   (RDaddr_o)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of instructions with expected write-back
// results, a memory responder with programmable ack delay, and corner sequences.
module tb_mem_wb_stage;

    localparam int TO = 16;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RTdata_i;
    logic [4:0]  RDaddr_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] ALUResult_o;
    logic [31:0] ReadData_o;
    logic [4:0]  RDaddr_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rdaddr;
        int          ack_dly;
        logic [31:0] rdata;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
    } vec_t;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        chk_rdata;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp;
    int          n_fail;
    int          ack_dly;
    logic [31:0] rsp_rdata;
    logic        spur_ack;
    logic [31:0] prev_alu;
    logic        exp_err;
    int          cyc_cnt = 0;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ALUResult_i (ALUResult_i),
        .RTdata_i    (RTdata_i),
        .RDaddr_i    (RDaddr_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALUResult_o (ALUResult_o),
        .ReadData_o  (ReadData_o),
        .RDaddr_o    (RDaddr_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Memory model: acks in the ack_dly-th cycle of an outstanding request.
    initial begin : responder
        int wcnt;
        wcnt        = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) wcnt++;
            else wcnt = 0;
            if (spur_ack || (mem_req_o === 1'b1 && ack_dly > 0 && wcnt == ack_dly)) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rsp_rdata;
            end
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h5A5A_5A5A;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic rd, input logic wr, input logic rw, input logic m2r,
                                   input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rdaddr,
                                   input int ack_d, input logic [31:0] rdata, input int exp_stall,
                                   input logic [31:0] exp_rdata, input logic chk_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r;
        v.alu = alu; v.wdata = wdata; v.rdaddr = rdaddr;
        v.ack_dly = ack_d; v.rdata = rdata;
        v.exp_stall = exp_stall; v.exp_rdata = exp_rdata; v.chk_rdata = chk_rdata;
        return v;
    endfunction

    // Presents one instruction, holds it while stalled, then checks the write-back.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t        e;
        exp_t        got;
        int          stalls;
        logic        done;
        logic        bub_ok;
        logic        we_ok;
        logic        addr_ok;
        logic        acc;
        logic [31:0] cnt0;
        acc         = v.rd | v.wr;
        MemRead_i   = v.rd;
        MemWrite_i  = v.wr;
        RegWrite_i  = v.rw;
        MemtoReg_i  = v.m2r;
        ALUResult_i = v.alu;
        RTdata_i    = v.wdata;
        RDaddr_i    = v.rdaddr;
        ack_dly     = v.ack_dly;
        rsp_rdata   = v.rdata;
        e.rw = v.rw; e.m2r = v.m2r; e.alu = v.alu; e.rdata = v.exp_rdata;
        e.rd = v.rdaddr; e.chk_rdata = v.chk_rdata;
        sbq.push_back(e);
        if (acc && v.ack_dly == 0) exp_err = 1'b1;
        cnt0    = stall_cnt_o;
        stalls  = 0;
        done    = 1'b0;
        bub_ok  = 1'b1;
        we_ok   = 1'b1;
        addr_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (stall_o !== 1'b1) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req_o === 1'b1) begin
                if (mem_we_o !== v.wr) we_ok = 1'b0;
                if (mem_addr_o !== v.alu) addr_ok = 1'b0;
                if (v.wr && mem_wdata_o !== v.wdata) addr_ok = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (RegWrite_o !== 1'b0 || MemtoReg_o !== 1'b0 || ALUResult_o !== prev_alu) bub_ok = 1'b0;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_complete: stall_o still high after 40 cycles", tag);
        end
        @(posedge clk_i);
        #1;
        check32({tag, "_stall_cycles"}, stalls, v.exp_stall);
        check32({tag, "_stall_cnt_delta"}, stall_cnt_o - cnt0, v.exp_stall);
        if (acc) begin
            check32({tag, "_bubble"}, {31'd0, bub_ok}, 32'd1);
            check32({tag, "_mem_we"}, {31'd0, we_ok}, 32'd1);
            check32({tag, "_mem_addr_data"}, {31'd0, addr_ok}, 32'd1);
        end
        if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            got = sbq.pop_front();
            check32({tag, "_RegWrite"}, {31'd0, RegWrite_o}, {31'd0, got.rw});
            check32({tag, "_MemtoReg"}, {31'd0, MemtoReg_o}, {31'd0, got.m2r});
            check32({tag, "_ALUResult"}, ALUResult_o, got.alu);
            check32({tag, "_RDaddr"}, {27'd0, RDaddr_o}, {27'd0, got.rd});
            if (got.chk_rdata) check32({tag, "_ReadData"}, ReadData_o, got.rdata);
            prev_alu = got.alu;
        end
        check32({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        vec_t        vt[9];
        int          c0;
        logic        no_replay;
        n_cmp     = 0;
        n_fail    = 0;
        ack_dly   = 0;
        rsp_rdata = '0;
        spur_ack  = 1'b0;
        prev_alu  = '0;
        exp_err   = 1'b0;

        //           rd    wr    rw    m2r   alu            wdata         rd    ack rdata          stall rdata_exp      chk
        vt[0] = mkvec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        5'd5,  0, 32'h0,         0,  32'h0,         1'b1);
        vt[1] = mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0,        5'd7,  3, 32'hDEAD_BEEF, 4,  32'hDEAD_BEEF, 1'b1);
        vt[2] = mkvec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h1234,     5'd0,  1, 32'h0,         2,  32'h0,         1'b0);
        vt[3] = mkvec(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        5'd31, 0, 32'h0,         0,  32'h0,         1'b1);
        vt[4] = mkvec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hCAFE,     5'd2,  2, 32'h7777_7777, 3,  32'h0,         1'b0);
        vt[5] = mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0,        5'd12, TO, 32'h0BAD_F00D, TO + 1, 32'h0BAD_F00D, 1'b1);
        vt[6] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0,        5'd3,  0, 32'h0,         0,  32'h0,         1'b1);
        vt[7] = mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0,        5'd13, 0, 32'h0,         TO + 1, 32'h0,     1'b1);
        vt[8] = mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h0,        5'd14, 1, 32'h600D_CAFE, 2,  32'h600D_CAFE, 1'b1);

        rst_i       = 1'b0;
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b1;
        MemtoReg_i  = 1'b0;
        ALUResult_i = 32'h0;
        RTdata_i    = 32'h0;
        RDaddr_i    = 5'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check32("rst_stall", {31'd0, stall_o}, 32'd0);
        check32("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check32("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check32("rst_RegWrite", {31'd0, RegWrite_o}, 32'd0);
        check32("rst_ALUResult", ALUResult_o, 32'd0);
        check32("rst_ReadData", ReadData_o, 32'd0);
        check32("rst_err", {31'd0, err_o}, 32'd0);
        check32("rst_stall_cnt", stall_cnt_o, 32'd0);
        MemRead_i  = 1'b0;
        RegWrite_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // An ack while idle must not disturb the next access.
        spur_ack = 1'b1;
        run_vec(mkvec(1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 5'd9, 0, 32'h0, 0, 32'h0, 1'b1), "spur_nop");
        spur_ack = 1'b0;
        run_vec(mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd8, 2, 32'h1111_2222, 3, 32'h1111_2222, 1'b1), "spur_load");

        // Reset while a load is waiting: request and stall drop without a clock edge.
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b1;
        MemtoReg_i  = 1'b1;
        ALUResult_i = 32'h600;
        RDaddr_i    = 5'd4;
        ack_dly     = 0;
        repeat (3) @(posedge clk_i);
        #2;
        check32("wait_pre_req", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check32("wait_rst_req", {31'd0, mem_req_o}, 32'd0);
        check32("wait_rst_stall", {31'd0, stall_o}, 32'd0);
        check32("wait_rst_err", {31'd0, err_o}, 32'd0);
        check32("wait_rst_stall_cnt", stall_cnt_o, 32'd0);
        MemRead_i   = 1'b0;
        RegWrite_i  = 1'b0;
        MemtoReg_i  = 1'b0;
        ALUResult_i = 32'h0;
        RDaddr_i    = 5'd0;
        exp_err     = 1'b0;
        prev_alu    = 32'h0;
        @(negedge clk_i);
        rst_i     = 1'b1;
        no_replay = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (mem_req_o !== 1'b0 || stall_o !== 1'b0) no_replay = 1'b0;
        end
        check32("wait_rst_no_replay", {31'd0, no_replay}, 32'd1);
        @(posedge clk_i);
        #1;
        run_vec(mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h700, 32'h0, 5'd6, 2, 32'h89AB_CDEF, 3, 32'h89AB_CDEF, 1'b1), "post_rst_load");

        // Back-to-back loads acked immediately occupy exactly six cycles.
        c0 = cyc_cnt;
        run_vec(mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h800, 32'h0, 5'd10, 1, 32'hAAAA_0001, 2, 32'hAAAA_0001, 1'b1), "b2b_a");
        run_vec(mkvec(1'b1, 1'b0, 1'b1, 1'b1, 32'h804, 32'h0, 5'd11, 1, 32'hBBBB_0002, 2, 32'hBBBB_0002, 1'b1), "b2b_b");
        check32("b2b_cycles", cyc_cnt - c0, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
